// File: rtl/match_popcount_acc.sv
// match_popcount_acc
//   Correlation accumulator for the acquisition engine. Each valid match
//   vector is reduced to a ones-count by a tree of 3:2 full-adder
//   compressors. The counts are then summed over a programmable block length,
//   and one registered, saturated sum is emitted per block.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous flush of the pipeline and the block in progress
//   in_valid   in_data valid this cycle
//   in_data    IN_WIDTH-bit match vector (1 = sign agreement)
//   acc_len    vectors per block, 0 encodes 1024; captured with a block's first vector
//   out_valid  one-cycle pulse, out_sum/out_sat valid
//   out_sum    block sum, clamped to 2^ACC_WIDTH-1, held until the next result
//   out_sat    block sum saturated, qualified by out_valid
//   busy       block in progress (first vector accepted, result not yet emitted)
module match_popcount_acc #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [9:0]           acc_len,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int PW = $clog2(IN_WIDTH + 1);
  // Column width has two spare bits so the fixed 3-bit taps stay in range
  // even for very narrow inputs.
  localparam int CW = IN_WIDTH + 2;
  localparam int LW = 11;

  typedef enum logic {IDLE, ACC} state_t;

  // One full adder: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Column-wise compressor tree. Each column is a packed list of bits of
  // equal weight; three bits at a time go through a full adder (a lone pair
  // goes through one with a zero third input). The sum stays in the column
  // and the carry moves to the next one, until each column holds one bit.
  // The bit counts are data-independent, so the loops unroll into a fixed tree.
  function automatic logic [PW-1:0] popcount(input logic [IN_WIDTH-1:0] v);
    logic [CW-1:0] col [PW];
    int            n   [PW];
    logic [1:0]    fo;
    logic [PW-1:0] res;
    res = '0;
    for (int w = 0; w < PW; w++) begin
      col[w] = '0;
      n[w]   = 0;
    end
    col[0] = CW'(v);
    n[0]   = IN_WIDTH;
    for (int w = 0; w < PW; w++) begin
      for (int it = 0; it < IN_WIDTH; it++) begin
        if (n[w] >= 3) begin
          fo     = fa(col[w][0], col[w][1], col[w][2]);
          col[w] = (col[w] >> 3) | (CW'(fo[0]) << (n[w] - 3));
          n[w]   = n[w] - 2;
          if (w + 1 < PW) begin
            col[w+1] = col[w+1] | (CW'(fo[1]) << n[w+1]);
            n[w+1]   = n[w+1] + 1;
          end
        end else if (n[w] == 2) begin
          fo     = fa(col[w][0], col[w][1], 1'b0);
          col[w] = CW'(fo[0]);
          n[w]   = 1;
          if (w + 1 < PW) begin
            col[w+1] = col[w+1] | (CW'(fo[1]) << n[w+1]);
            n[w+1]   = n[w+1] + 1;
          end
        end
      end
      res[w] = col[w][0];
    end
    return res;
  endfunction

  // Clamp a guarded sum. The result's top bit is the overflow flag and the
  // low ACC_WIDTH bits are the clamped value.
  function automatic logic [ACC_WIDTH:0] sat_sum(input logic [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH]) return {1'b1, {ACC_WIDTH{1'b1}}};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  logic [PW-1:0]        pop_p1;
  logic                 vld_p1;
  logic [9:0]           len_p1;

  state_t               state, state_n;
  logic [ACC_WIDTH:0]   acc, acc_n;
  logic [LW-1:0]        cnt, cnt_n;
  logic [LW-1:0]        len, len_n;
  logic                 sat, sat_n;
  logic                 out_valid_n;
  logic [ACC_WIDTH-1:0] out_sum_n;
  logic                 out_sat_n;

  logic [ACC_WIDTH:0]   sum_p2;
  logic [ACC_WIDTH:0]   clamp_p2;
  logic                 sat_run_p2;
  logic [LW-1:0]        cnt_inc_p2;
  logic [LW-1:0]        lim_p2;

  // ---- Stage P1: popcount (acc_len travels with the vector) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_p1 <= '0;
      vld_p1 <= 1'b0;
      len_p1 <= '0;
    end else begin
      pop_p1 <= popcount(in_data);
      vld_p1 <= in_valid & ~clear;
      len_p1 <= acc_len;
    end
  end

  // ---- Stage P2: block accumulate / finish ----
  // acc and cnt are zero in IDLE, so the first vector of a block takes the
  // same add/increment path as the rest; only the length limit differs.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    len_n       = len;
    sat_n       = sat;
    out_valid_n = 1'b0;
    out_sum_n   = out_sum;
    out_sat_n   = out_sat;

    sum_p2     = acc + (ACC_WIDTH+1)'(pop_p1);
    clamp_p2   = sat_sum(sum_p2);
    sat_run_p2 = sat | clamp_p2[ACC_WIDTH];
    cnt_inc_p2 = cnt + LW'(1);
    if (state == IDLE) lim_p2 = (len_p1 == '0) ? LW'(1024) : {1'b0, len_p1};
    else               lim_p2 = len;

    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      cnt_n   = '0;
      sat_n   = 1'b0;
    end else if (vld_p1) begin
      if (cnt_inc_p2 == lim_p2) begin
        out_valid_n = 1'b1;
        out_sum_n   = clamp_p2[ACC_WIDTH-1:0];
        out_sat_n   = sat_run_p2;
        state_n     = IDLE;
        acc_n       = '0;
        cnt_n       = '0;
        sat_n       = 1'b0;
      end else begin
        state_n = ACC;
        acc_n   = {1'b0, clamp_p2[ACC_WIDTH-1:0]};
        cnt_n   = cnt_inc_p2;
        len_n   = lim_p2;
        sat_n   = sat_run_p2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      len       <= len_n;
      sat       <= sat_n;
      out_valid <= out_valid_n;
      out_sum   <= out_sum_n;
      out_sat   <= out_sat_n;
    end
  end

  assign busy = (state == ACC);

endmodule

// File: tb/tb_match_popcount_acc.sv
module tb_match_popcount_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [9:0]  acc_len = '0;

  logic        ov16, st16, by16;
  logic [15:0] os16;
  logic        ov8, st8, by8;
  logic [7:0]  os8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  match_popcount_acc #(.IN_WIDTH(16), .ACC_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .acc_len(acc_len), .out_valid(ov16), .out_sum(os16), .out_sat(st16), .busy(by16));

  match_popcount_acc #(.IN_WIDTH(16), .ACC_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .acc_len(acc_len), .out_valid(ov8), .out_sum(os8), .out_sat(st8), .busy(by8));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Block-level reference: total ones per block, clamped at the end.
  // A vector seen at one edge is accounted at the next edge; a clear drops
  // the vector seen at the previous edge, the current one and the block.
  bit m_act = 0;
  int m_tot = 0, m_cnt = 0, m_len = 0;
  bit p_v = 0;
  int p_pop = 0, p_len = 0;
  bit e_v = 0;
  int e_sum16 = 0, e_sat16 = 0, e_sum8 = 0, e_sat8 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_tot = 0; m_cnt = 0; m_len = 0;
      p_v = 0; p_pop = 0; p_len = 0;
      e_v = 0; e_sum16 = 0; e_sat16 = 0; e_sum8 = 0; e_sat8 = 0;
    end else if (clear) begin
      p_v = 0; m_act = 0; e_v = 0;
    end else begin
      e_v = 0;
      if (p_v) begin
        if (!m_act) begin
          m_act = 1; m_tot = 0; m_cnt = 0; m_len = p_len;
        end
        m_tot += p_pop;
        m_cnt++;
        if (m_cnt == m_len) begin
          e_v     = 1;
          m_act   = 0;
          e_sum16 = (m_tot > 65535) ? 65535 : m_tot;
          e_sat16 = (m_tot > 65535) ? 1 : 0;
          e_sum8  = (m_tot > 255) ? 255 : m_tot;
          e_sat8  = (m_tot > 255) ? 1 : 0;
        end
      end
      p_v   = in_valid;
      p_pop = $countones(in_data);
      p_len = (acc_len == 0) ? 1024 : int'(acc_len);
    end
  end

  always @(negedge clk) begin
    chk("valid16", ov16, e_v);
    chk("busy16",  by16, m_act);
    chk("sum16",   os16, e_sum16);
    chk("sat16",   st16, e_sat16);
    chk("valid8",  ov8,  e_v);
    chk("busy8",   by8,  m_act);
    chk("sum8",    os8,  e_sum8);
    chk("sat8",    st8,  e_sat8);
  end

  // Result log for the literal checks.
  int np = 0;
  int psum [64];
  int pcyc [64];
  int l16sat = 0, l8sum = 0, l8sat = 0;
  int bcnt = 0;
  always @(negedge clk) begin
    if (by16) bcnt++;
    if (ov16 && np < 64) begin
      psum[np] = os16; pcyc[np] = cyc; l16sat = st16; np++;
    end
    if (ov8) begin
      l8sum = os8; l8sat = st8;
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask
  task automatic vec(input logic [15:0] d); drive(1'b1, d, 1'b0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0); endtask

  int n0, clast;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", ov16, 0); chk("rst_sum", os16, 0);
    chk("rst_sat", st16, 0);   chk("rst_busy", by16, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset in the middle of a block, with a vector being presented
    acc_len = 10'd4;
    vec(16'hFFFF); vec(16'hFFFF);
    in_valid = 1'b1; in_data = 16'hFFFF;
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", by16, 0); chk("midrst_valid", ov16, 0);
    chk("midrst_sum", os16, 0);  chk("midrst_sat", st16, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    chk("midrst_no_pulse", np, 0);

    // basic block: 16+1+8+0
    n0 = np; bcnt = 0; acc_len = 10'd4;
    vec(16'hFFFF); vec(16'h0001); vec(16'h00FF); vec(16'h0000);
    clast = cyc;
    idle(4);
    chk("basic_pulses", np - n0, 1);
    chk("basic_sum", psum[n0], 25);
    chk("basic_sat", l16sat, 0);
    chk("basic_latency", pcyc[n0] - clast, 1);
    chk("basic_busy_cycles", bcnt, 3);

    // gaps only stretch the block
    n0 = np; acc_len = 10'd3;
    vec(16'h000F); idle(2); vec(16'h000F); idle(1); vec(16'h000F);
    idle(4);
    chk("gap_pulses", np - n0, 1);
    chk("gap_sum", psum[n0], 12);

    // one-vector blocks back to back
    n0 = np; acc_len = 10'd1;
    vec(16'h0003); vec(16'h0007);
    idle(3);
    chk("len1_pulses", np - n0, 2);
    chk("len1_sum_a", psum[n0], 2);
    chk("len1_sum_b", psum[n0+1], 3);
    chk("len1_adjacent", pcyc[n0+1] - pcyc[n0], 1);

    // acc_len=0 means 1024; a mid-block change is ignored
    n0 = np; acc_len = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 10) acc_len = 10'd2;
      vec(16'hFFFF);
    end
    idle(4);
    chk("len1024_pulses", np - n0, 1);
    chk("len1024_sum", psum[n0], 16384);
    chk("len1024_sat", l16sat, 0);
    chk("len1024_sum8", l8sum, 255);
    chk("len1024_sat8", l8sat, 1);

    // saturation in the 8-bit instance
    n0 = np; acc_len = 10'd20;
    for (int i = 0; i < 20; i++) vec(16'hFFFF);
    idle(4);
    chk("sat_sum8", l8sum, 255);
    chk("sat_flag8", l8sat, 1);
    chk("sat_sum16", psum[n0], 320);
    acc_len = 10'd2;
    vec(16'h0001); vec(16'h0001);
    idle(4);
    chk("after_sat_sum8", l8sum, 2);
    chk("after_sat_flag8", l8sat, 0);

    // clear aborts a block
    n0 = np; acc_len = 10'd4;
    vec(16'h0001); vec(16'h0001);
    drive(1'b1, 16'h0001, 1'b1);
    chk("clear_busy", by16, 0);
    chk("clear_valid", ov16, 0);
    chk("clear_hold_sum", os16, 2);
    idle(2);
    for (int i = 0; i < 4; i++) vec(16'h0011);
    idle(4);
    chk("clear_pulses", np - n0, 1);
    chk("clear_next_sum", psum[n0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
